// File: rtl/viterbi_decoder_if.sv
// Symbol stream handshake between the channel front end and the Viterbi decoder.
// Code-rate selector encodings shared by the decoder and its sources.
`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

interface viterbi_decoder_if #(
  parameter int CODE_RATE_MAX = 3
) ();
  logic [CODE_RATE_MAX-1:0] i_sym;
  logic                     i_sym_valid;
  logic                     o_sym_ready;

  modport master (output i_sym, output i_sym_valid, input o_sym_ready);
  modport slave  (input i_sym, input i_sym_valid, output o_sym_ready);
endinterface

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder: per-symbol ACS with survivor storage, then
// a minimum-metric scan and a full-frame traceback to the parallel output.
module viterbi_decoder #(
  parameter int K             = 7,
  parameter int CODE_RATE_MAX = 3,
  parameter int FRAME_LEN     = 128,
  parameter int MET_W         = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [K-1:0]         i_gen_poly [CODE_RATE_MAX],
  input  logic                 i_code_rate,
  viterbi_decoder_if.slave     sym_if,
  output logic [FRAME_LEN-1:0] o_dec_data,
  output logic                 o_dec_done,
  output logic [MET_W-1:0]     o_path_metric,
  output logic                 o_busy
);

  localparam int SW        = K - 1;
  localparam int STATE_NUM = 1 << SW;
  localparam int STEP_W    = $clog2(FRAME_LEN + 1);
  localparam int TB_W      = $clog2(FRAME_LEN);
  localparam int BM_W      = $clog2(CODE_RATE_MAX + 1);
  localparam logic [MET_W-1:0] PM_INIT = {2'b01, {(MET_W-2){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACS,
    ST_FIND_MIN,
    ST_TRACEBACK,
    ST_DONE
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [STEP_W-1:0]     step_r;
  logic [SW-1:0]         idx_r;
  logic [TB_W-1:0]       tb_t_r;
  logic [TB_W-1:0]       tb_idx_s;
  logic                  rate3_r, rate3_s;
  logic [MET_W-1:0]      pm_r     [STATE_NUM];
  logic [MET_W-1:0]      pm_nxt_s [STATE_NUM];
  logic [STATE_NUM-1:0]  dec_vec_s;
  logic [STATE_NUM-1:0]  surv_r   [FRAME_LEN];
  logic [MET_W-1:0]      best_pm_r, min_pm_s;
  logic [SW-1:0]         best_st_r, min_st_s;
  logic [SW-1:0]         cur_r;
  logic [FRAME_LEN-1:0]  dec_r;
  logic                  sym_ready_r, busy_r, done_r;
  logic                  xfer_s;

  function automatic logic [BM_W-1:0] branch_metric(input logic [K-1:0] word,
                                                    input logic [CODE_RATE_MAX-1:0] sym,
                                                    input logic rate3);
    logic [BM_W-1:0] bm;
    bm = '0;
    for (int i = 0; i < CODE_RATE_MAX; i++) begin
      if ((i < 2) || rate3) begin
        bm = bm + {{(BM_W-1){1'b0}}, (^(word & i_gen_poly[i])) ^ sym[i]};
      end else begin
        bm = bm;
      end
    end
    return bm;
  endfunction

  // Predecessor {d, n[SW-1:1]} entering state n emits the code word of register {d, n}.
  function automatic logic [MET_W-1:0] path_cand(input logic d, input logic [SW-1:0] n,
                                                 input logic [CODE_RATE_MAX-1:0] sym,
                                                 input logic rate3);
    logic [SW-1:0] pred;
    pred = {d, n[SW-1:1]};
    return pm_r[pred] + {{(MET_W-BM_W){1'b0}}, branch_metric({d, n}, sym, rate3)};
  endfunction

  assign xfer_s             = sym_if.i_sym_valid & sym_ready_r;
  assign tb_idx_s           = TB_W'(FRAME_LEN - 1) - tb_t_r;
  assign sym_if.o_sym_ready = sym_ready_r;
  assign o_busy             = busy_r;
  assign o_dec_done         = done_r;

  // Add-compare-select across all states; a tie keeps the d=0 predecessor.
  always_comb begin
    logic [MET_W-1:0] c0_v, c1_v;
    c0_v      = '0;
    c1_v      = '0;
    dec_vec_s = '0;
    pm_nxt_s  = pm_r;
    if (state_r == ST_IDLE) begin
      rate3_s = (i_code_rate == `CODE_RATE_3);
    end else begin
      rate3_s = rate3_r;
    end
    for (int n = 0; n < STATE_NUM; n++) begin
      c0_v = path_cand(1'b0, SW'(n), sym_if.i_sym, rate3_s);
      c1_v = path_cand(1'b1, SW'(n), sym_if.i_sym, rate3_s);
      if (c1_v < c0_v) begin
        dec_vec_s[n] = 1'b1;
        pm_nxt_s[n]  = c1_v;
      end else begin
        dec_vec_s[n] = 1'b0;
        pm_nxt_s[n]  = c0_v;
      end
    end
  end

  // Running minimum of the final metrics; strict less-than keeps the lowest index.
  always_comb begin
    min_pm_s = best_pm_r;
    min_st_s = best_st_r;
    if ((idx_r == '0) || (pm_r[idx_r] < best_pm_r)) begin
      min_pm_s = pm_r[idx_r];
      min_st_s = idx_r;
    end else begin
      min_pm_s = best_pm_r;
      min_st_s = best_st_r;
    end
  end

  // Next-state logic of the frame sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) state_nxt_s = ST_ACS;
        else        state_nxt_s = ST_IDLE;
      end
      ST_ACS: begin
        if (xfer_s && (step_r == STEP_W'(FRAME_LEN - 1))) state_nxt_s = ST_FIND_MIN;
        else                                               state_nxt_s = ST_ACS;
      end
      ST_FIND_MIN: begin
        if (idx_r == '1) state_nxt_s = ST_TRACEBACK;
        else             state_nxt_s = ST_FIND_MIN;
      end
      ST_TRACEBACK: begin
        if (tb_t_r == '0) state_nxt_s = ST_DONE;
        else              state_nxt_s = ST_TRACEBACK;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Survivor decisions; every entry read in traceback is written earlier in the same frame.
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      surv_r[step_r[TB_W-1:0]] <= dec_vec_s;
    end
  end

  // Sequencer state, path metrics, scan/traceback registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      step_r        <= '0;
      idx_r         <= '0;
      tb_t_r        <= '0;
      rate3_r       <= 1'b0;
      for (int s = 0; s < STATE_NUM; s++) pm_r[s] <= (s == 0) ? '0 : PM_INIT;
      best_pm_r     <= '0;
      best_st_r     <= '0;
      cur_r         <= '0;
      dec_r         <= '0;
      o_dec_data    <= '0;
      o_path_metric <= '0;
      sym_ready_r   <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sym_ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ACS);
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= (state_r == ST_DONE);
      case (state_r)
        ST_IDLE, ST_ACS: begin
          if (xfer_s) begin
            pm_r   <= pm_nxt_s;
            step_r <= step_r + STEP_W'(1);
            if (state_r == ST_IDLE) rate3_r <= rate3_s;
            else                    rate3_r <= rate3_r;
          end
        end
        ST_FIND_MIN: begin
          idx_r     <= idx_r + SW'(1);
          best_pm_r <= min_pm_s;
          best_st_r <= min_st_s;
          if (idx_r == '1) begin
            cur_r  <= min_st_s;
            tb_t_r <= TB_W'(FRAME_LEN - 1);
          end
        end
        ST_TRACEBACK: begin
          dec_r[tb_idx_s] <= cur_r[0];
          cur_r           <= {surv_r[tb_t_r][cur_r], cur_r[SW-1:1]};
          tb_t_r          <= tb_t_r - TB_W'(1);
        end
        ST_DONE: begin
          o_dec_data    <= dec_r;
          o_path_metric <= best_pm_r;
          step_r        <= '0;
          for (int s = 0; s < STATE_NUM; s++) pm_r[s] <= (s == 0) ? '0 : PM_INIT;
        end
        default: begin
          step_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed and randomized frames encoded by a bench-side convolutional encoder
// and checked against the known payload and injected error count.
`timescale 1ns/1ps
`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module tb_viterbi_decoder;
  localparam int K  = 7;
  localparam int R  = 3;
  localparam int FL = 128;
  localparam int MW = 11;
  localparam int LATENCY = 64 + FL + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [K-1:0]  gen_poly [R];
  logic          code_rate;
  logic [FL-1:0] dec_data;
  logic          dec_done;
  logic [MW-1:0] path_metric;
  logic          busy;

  viterbi_decoder_if #(.CODE_RATE_MAX(R)) sif ();

  viterbi_decoder #(.K(K), .CODE_RATE_MAX(R), .FRAME_LEN(FL), .MET_W(MW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_gen_poly    (gen_poly),
    .i_code_rate   (code_rate),
    .sym_if        (sif),
    .o_dec_data    (dec_data),
    .o_dec_done    (dec_done),
    .o_path_metric (path_metric),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [R-1:0]  syms [FL];
  logic          rate3;
  logic [FL-1:0] payload;

  always @(negedge clk) if (dec_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [FL-1:0] obs, input logic [FL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: register word holds the newest bit at position 0.
  task automatic build_frame(input logic [FL-1:0] data, input int f0, input int f1, input int f2);
    int hist = 0;
    for (int j = 0; j < FL; j++) begin
      hist = ((hist << 1) | int'(data[FL-1-j])) & ((1 << K) - 1);
      for (int i = 0; i < R; i++) begin
        logic par = 1'b0;
        for (int k = 0; k < K; k++) if (hist[k] && gen_poly[i][k]) par = ~par;
        syms[j][i] = par;
      end
      if (!rate3) syms[j][2] = 1'($urandom);
      if (j == f0 || j == f1 || j == f2) begin
        int b = int'($urandom_range(0, rate3 ? 2 : 1));
        syms[j][b] = ~syms[j][b];
      end
    end
  endtask

  // Called on a falling edge; the transfer happens on the next rising edge with ready high.
  task automatic put_sym(input logic [R-1:0] s, output bit ok);
    int n = 0;
    sif.i_sym       = s;
    sif.i_sym_valid = 1'b1;
    while (sif.o_sym_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = (sif.o_sym_ready === 1'b1);
    @(negedge clk);
    sif.i_sym_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [FL-1:0] exp_data, input int exp_met,
                           input bit gaps, input bit toggle_rate);
    int  n    = 0;
    int  base = done_cnt;
    bit  ok;
    bit  all_ok = 1'b1;
    bit  bad_hs = 1'b0;
    logic saved_rate = code_rate;
    for (int j = 0; j < FL; j++) begin
      if (gaps) while ($urandom_range(0, 1) == 1) @(negedge clk);
      put_sym(syms[j], ok);
      all_ok &= ok;
      if (toggle_rate && j == 0) code_rate = ~code_rate;
    end
    code_rate = saved_rate;
    check({tag, ".accept"}, FL'(all_ok), FL'(1));
    while (dec_done !== 1'b1 && n < 400) begin
      if (sif.o_sym_ready !== 1'b0 || busy !== 1'b1) bad_hs = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, FL'(n), FL'(LATENCY));
    check({tag, ".ready_busy"}, FL'(bad_hs), FL'(0));
    check({tag, ".data"}, dec_data, exp_data);
    check({tag, ".metric"}, FL'(path_metric), FL'(exp_met));
    check({tag, ".busy_at_done"}, FL'(busy), FL'(0));
    @(negedge clk);
    check({tag, ".done_pulse"}, FL'(dec_done), FL'(0));
    check({tag, ".data_hold"}, dec_data, exp_data);
    check({tag, ".done_count"}, FL'(done_cnt - base), FL'(1));
  endtask

  initial begin
    bit ok;
    int base;
    sif.i_sym       = '0;
    sif.i_sym_valid = 1'b0;
    code_rate       = `CODE_RATE_2;
    rate3           = 1'b0;
    gen_poly[0]     = 7'o171;
    gen_poly[1]     = 7'o133;
    gen_poly[2]     = 7'o000;
    repeat (3) @(negedge clk);
    check("rst.data", dec_data, '0);
    check("rst.metric", FL'(path_metric), FL'(0));
    check("rst.done", FL'(dec_done), FL'(0));
    check("rst.ready", FL'(sif.o_sym_ready), FL'(0));
    check("rst.busy", FL'(busy), FL'(0));
    rst = 1'b1;
    @(negedge clk);
    check("idle.ready", FL'(sif.o_sym_ready), FL'(1));
    check("idle.busy", FL'(busy), FL'(0));

    for (int j = 0; j < FL; j++) syms[j] = '0;
    run_frame("zero", '0, 0, 1'b0, 1'b0);

    payload = 128'hDEADBEEF_0123_4567_89AB_CDEF_5A5A_A5A5;
    build_frame(payload, -1, -1, -1);
    run_frame("clean", payload, 0, 1'b0, 1'b0);

    build_frame(payload, 10, 90, -1);
    run_frame("flip2", payload, 2, 1'b0, 1'b0);

    gen_poly[2] = 7'o165;
    code_rate   = `CODE_RATE_3;
    rate3       = 1'b1;
    payload     = {$urandom, $urandom, $urandom, $urandom};
    build_frame(payload, 20, 55, 90);
    run_frame("r3flip3", payload, 3, 1'b0, 1'b1);
    run_frame("r3gaps", payload, 3, 1'b1, 1'b0);

    code_rate = `CODE_RATE_2;
    rate3     = 1'b0;
    payload   = {$urandom, $urandom, $urandom, $urandom};
    build_frame(payload, -1, -1, -1);
    base = done_cnt;
    for (int j = 0; j < 60; j++) put_sym(syms[j], ok);
    rst = 1'b0;
    #1;
    check("abort.data", dec_data, '0);
    check("abort.metric", FL'(path_metric), FL'(0));
    check("abort.ready", FL'(sif.o_sym_ready), FL'(0));
    check("abort.busy", FL'(busy), FL'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check("abort.no_done", FL'(done_cnt - base), FL'(0));
    check("abort.idle", FL'(busy), FL'(0));

    payload = {$urandom, $urandom, $urandom, $urandom};
    build_frame(payload, -1, -1, -1);
    run_frame("post_rst", payload, 0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
